// File: rtl/time_set_controller_pkg.sv
// Shared encodings for the desk-clock time-set controller.
// The optional auto-repeat feature is enabled by defining AUTO_REPEAT_EN.
package time_set_controller_pkg;

    // Width of the auto-repeat strobe counter; REPEAT_DELAY must fit in it.
    localparam int RPT_CNT_W = 4;

    // Mode encodings as seen on o_mode.
    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_MIN  = 2'd1;
    localparam logic [1:0] MODE_SET_HOUR = 2'd2;

    // FSM states share the o_mode encoding so the state register drives o_mode directly.
    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_MIN  = MODE_SET_MIN,
        ST_SET_HOUR = MODE_SET_HOUR
    } state_t;

    // Decode the next state of a button-driven transition from the current state and buttons.
    // Hours win over minutes from RUN; a set state only watches its own button.
    function automatic state_t next_mode(input state_t cur, input logic set_min, input logic set_hour);
        state_t nxt;
        nxt = cur;
        case (cur)
            ST_RUN: begin
                if (set_hour)
                    nxt = ST_SET_HOUR;
                else if (set_min)
                    nxt = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (!set_min)
                    nxt = ST_RUN;
            end
            ST_SET_HOUR: begin
                if (!set_hour)
                    nxt = ST_RUN;
            end
            default: nxt = ST_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/time_set_controller_repeat_timer.sv
// Auto-repeat timer for the time-set controller.
// Only instantiated when AUTO_REPEAT_EN is defined.
// fire is combinational: high on the clear (entry) cycle, and on every strobe
// once REPEAT_DELAY strobes have been counted since the clear.
module repeat_timer
    import time_set_controller_pkg::*;
#(
    parameter int REPEAT_DELAY = 4
) (
    input  logic i_sysclk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic strobe,
    output logic fire
);

    localparam logic [RPT_CNT_W-1:0] DELAY = RPT_CNT_W'(REPEAT_DELAY);

    logic [RPT_CNT_W-1:0] cnt;
    logic                 sat;

    assign sat = (cnt == DELAY);

    // Count strobes up to the delay; a strobe coincident with clear is the first count.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= strobe ? RPT_CNT_W'(1) : '0;
        else if (strobe && !sat)
            cnt <= cnt + RPT_CNT_W'(1);
    end

    // Entry always fires; post-entry strobes fire only when the counter was already saturated.
    assign fire = clear | (strobe & sat);

endmodule

// File: rtl/time_set_controller.sv
// Run/set sequencing controller for the seconds/minutes/hours counter chain.
// Define AUTO_REPEAT_EN to enable auto-repeat of set pulses from i_fast_stb;
// without it each button press yields a single increment.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int REPEAT_DELAY = 4
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    input  logic       i_1hz_stb,
    input  logic       i_fast_stb,
    input  logic       i_set_minutes,
    input  logic       i_set_hours,
    input  logic       i_sec_overflow,
    input  logic       i_min_overflow,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hour_en,
    output logic       o_sec_clr,
    output logic [1:0] o_mode
);

    state_t state, state_nxt;
    logic   entry;
    logic   fire;
    logic   sec_en_nxt, min_en_nxt, hour_en_nxt;

    // Entering a set state: the cycle the FSM leaves RUN.
    assign entry = (state == ST_RUN) && (state_nxt != ST_RUN);

`ifdef AUTO_REPEAT_EN
    logic stay_set;
    logic rpt_strobe;

    // Strobes count only while the set state is being kept (or entered); a release wins over a strobe.
    assign stay_set   = (state != ST_RUN) && (state_nxt == state);
    assign rpt_strobe = i_fast_stb && (entry || stay_set);

    repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY)
    ) u_repeat_timer (
        .i_sysclk  (i_sysclk),
        .i_reset_n (i_reset_n),
        .clear     (entry),
        .strobe    (rpt_strobe),
        .fire      (fire)
    );
`else
    logic unused_rpt;

    // Without auto-repeat only the entry pulse is issued.
    assign fire       = entry;
    assign unused_rpt = ^{i_fast_stb, RPT_CNT_W'(REPEAT_DELAY)};
`endif

    // Next-state decode and next-cycle enable pulses.
    always_comb begin
        state_nxt   = next_mode(state, i_set_minutes, i_set_hours);
        sec_en_nxt  = 1'b0;
        min_en_nxt  = 1'b0;
        hour_en_nxt = 1'b0;
        if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
            // Normal timekeeping: forward the strobe and cascade overflows.
            sec_en_nxt  = i_1hz_stb;
            min_en_nxt  = i_sec_overflow;
            hour_en_nxt = i_min_overflow;
        end else begin
            // Set states ignore the timebase and overflows so no carry happens.
            min_en_nxt  = fire && (state_nxt == ST_SET_MIN);
            hour_en_nxt = fire && (state_nxt == ST_SET_HOUR);
        end
    end

    // State register; o_mode is taken straight from it.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Registered enable pulses and seconds clear.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sec_en  <= 1'b0;
            o_min_en  <= 1'b0;
            o_hour_en <= 1'b0;
            o_sec_clr <= 1'b0;
        end else begin
            o_sec_en  <= sec_en_nxt;
            o_min_en  <= min_en_nxt;
            o_hour_en <= hour_en_nxt;
            o_sec_clr <= (state_nxt != ST_RUN);
        end
    end

    assign o_mode = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller. Expected enable pulses are queued
// by the stimulus with the cycle they must appear; a monitor pops them.
// Expectations follow AUTO_REPEAT_EN the same way the design does.
module tb_time_set_controller;

`ifdef AUTO_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    localparam logic [2:0] K_SEC  = 3'b001;
    localparam logic [2:0] K_MIN  = 3'b010;
    localparam logic [2:0] K_HOUR = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       one_hz, fast, set_min, set_hr, sec_ov, min_ov;
    logic       o_sec_en, o_min_en, o_hour_en, o_sec_clr;
    logic [1:0] o_mode;

    ev_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    time_set_controller #(.REPEAT_DELAY(4)) dut (
        .i_sysclk       (clk),
        .i_reset_n      (rst_n),
        .i_1hz_stb      (one_hz),
        .i_fast_stb     (fast),
        .i_set_minutes  (set_min),
        .i_set_hours    (set_hr),
        .i_sec_overflow (sec_ov),
        .i_min_overflow (min_ov),
        .o_sec_en       (o_sec_en),
        .o_min_en       (o_min_en),
        .o_hour_en      (o_hour_en),
        .o_sec_clr      (o_sec_clr),
        .o_mode         (o_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
        one_hz = 1'b0;
        fast   = 1'b0;
        sec_ov = 1'b0;
        min_ov = 1'b0;
    endtask

    task automatic exp_ev(input logic [2:0] kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every enable pulse must match the head of the expectation queue.
    initial begin
        ev_t        e;
        logic [2:0] act;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                act = {o_hour_en, o_min_en, o_sec_en};
                while (q.size() > 0 && q[0].at < cyc) begin
                    e = q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_pulse got=none want=kind%b@%0d now=%0d", e.kind, e.at, cyc);
                end
                if (act != 3'b000) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse got=kind%b@%0d want=none", act, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.kind != act || e.at != cyc) begin
                            bad++;
                            $display("FAIL pulse got=kind%b@%0d want=kind%b@%0d", act, cyc, e.kind, e.at);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; one_hz = 1'b0; fast = 1'b0; set_min = 1'b0;
        set_hr = 1'b0; sec_ov = 1'b0; min_ov = 1'b0;
        tick(); tick();
        chk("rst_mode", o_mode, 0);
        chk("rst_clr", o_sec_clr, 0);
        chk("rst_en", {o_hour_en, o_min_en, o_sec_en}, 0);
        rst_n = 1'b1;
        tick();

        // RUN forwarding of the 1 Hz strobe.
        one_hz = 1'b1; exp_ev(K_SEC, cyc + 1); tick(); tick();

        // Cascade: seconds wrap then minutes wrap.
        one_hz = 1'b1; exp_ev(K_SEC, cyc + 1); tick();
        sec_ov = 1'b1; exp_ev(K_MIN, cyc + 1); tick();
        min_ov = 1'b1; exp_ev(K_HOUR, cyc + 1); tick(); tick();
        chk("run_clr", o_sec_clr, 0);

        // Minute set held for 10 fast strobes.
        set_min = 1'b1; exp_ev(K_MIN, cyc + 1); tick();
        chk("setmin_mode", o_mode, 1);
        chk("setmin_clr", o_sec_clr, 1);
        for (int i = 0; i < 10; i++) begin
            fast = 1'b1;
            if (RPT_ON && i >= 4) exp_ev(K_MIN, cyc + 1);
            tick(); tick();
        end
        set_min = 1'b0; tick();
        chk("exit_min_mode", o_mode, 0);
        chk("exit_min_clr", o_sec_clr, 0);
        tick();

        // Both buttons together: hours win; releasing hours re-enters minutes via RUN.
        set_min = 1'b1; set_hr = 1'b1; exp_ev(K_HOUR, cyc + 1); tick();
        chk("both_mode", o_mode, 2);
        tick();
        set_hr = 1'b0; tick();
        chk("gap_mode", o_mode, 0);
        exp_ev(K_MIN, cyc + 1); tick();
        chk("remin_mode", o_mode, 1);
        set_min = 1'b0; tick(); tick();

        // Hour set ignores timebase and overflows; release with a strobe gives no pulse.
        set_hr = 1'b1; exp_ev(K_HOUR, cyc + 1); tick();
        one_hz = 1'b1; sec_ov = 1'b1; min_ov = 1'b1; tick(); tick();
        chk("sethour_clr", o_sec_clr, 1);
        for (int i = 0; i < 5; i++) begin
            fast = 1'b1;
            if (RPT_ON && i == 4) exp_ev(K_HOUR, cyc + 1);
            tick(); tick();
        end
        set_hr = 1'b0; fast = 1'b1; tick();
        chk("rel_fast_mode", o_mode, 0);
        chk("rel_fast_clr", o_sec_clr, 0);
        tick(); tick();

        // Hours held for 20 fast strobes.
        set_hr = 1'b1; exp_ev(K_HOUR, cyc + 1); tick();
        for (int i = 0; i < 20; i++) begin
            fast = 1'b1;
            if (RPT_ON && i >= 4) exp_ev(K_HOUR, cyc + 1);
            tick(); tick();
        end
        set_hr = 1'b0; tick(); tick();

        // Fast strobe in the entry cycle counts toward the delay, no extra pulse.
        set_min = 1'b1; fast = 1'b1; exp_ev(K_MIN, cyc + 1); tick();
        for (int i = 0; i < 4; i++) begin
            fast = 1'b1;
            if (RPT_ON && i == 3) exp_ev(K_MIN, cyc + 1);
            tick(); tick();
        end
        set_min = 1'b0; tick(); tick();

        // Asynchronous reset in the middle of a set pulse.
        set_hr = 1'b1; tick();
        chk("pre_rst_hour", o_hour_en, 1);
        chk("pre_rst_mode", o_mode, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_en", {o_hour_en, o_min_en, o_sec_en}, 0);
        chk("async_rst_mode", o_mode, 0);
        chk("async_rst_clr", o_sec_clr, 0);
        set_hr = 1'b0; tick();
        rst_n = 1'b1; tick();
        one_hz = 1'b1; exp_ev(K_SEC, cyc + 1); tick();
        tick(); tick(); tick();

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencing controller for the desk clock's seconds/minutes/hours overflow-counter chain. In run mode it forwards the 1 Hz strobe and cascades each counter's overflow pulse into the next counter's enable. In set mode, entered by holding a debounced set button, it drives minute or hour enables from a fast strobe with auto-repeat and holds seconds cleared. It sits between the strobe/button front end and the three counters.

## Interface
- REPEAT_DELAY, 4: fast strobes after the initial press before auto-repeat starts (1..15)
- i_sysclk  in  1  system clock (~50 MHz)
- i_reset_n  in  1  reset, asynchronous, active-low
- i_1hz_stb  in  1  one-cycle 1 Hz timebase pulse
- i_fast_stb  in  1  one-cycle set-rate pulse (~8 Hz)
- i_set_minutes  in  1  debounced level; minute-set button held
- i_set_hours  in  1  debounced level; hour-set button held
- i_sec_overflow  in  1  seconds counter overflow (already gated by its enable)
- i_min_overflow  in  1  minutes counter overflow (already gated by its enable)
- o_sec_en  out  1  seconds counter enable pulse
- o_min_en  out  1  minutes counter enable pulse
- o_hour_en  out  1  hours counter enable pulse
- o_sec_clr  out  1  high: seconds counter held at 0
- o_mode  out  2  0 RUN, 1 SET_MIN, 2 SET_HOUR

## Operation
- States: RUN, SET_MIN, SET_HOUR.
- RUN -> SET_HOUR if i_set_hours is high. Otherwise RUN -> SET_MIN if i_set_minutes is high. Hours have priority.
- SET_MIN -> RUN when i_set_minutes is low. SET_HOUR -> RUN when i_set_hours is low. The other button is ignored while in a set state.
- Every exit passes through RUN for at least one cycle. A still-held other button enters its set state on the next cycle and counts as a fresh press.
- RUN:
  - o_sec_en = i_1hz_stb.
  - o_min_en = i_sec_overflow.
  - o_hour_en = i_min_overflow.
  - o_sec_clr = 0.
- Set states:
  - o_sec_en = 0 and o_sec_clr = 1.
  - i_1hz_stb and both overflow inputs are ignored, so wrap-around does not carry (59 -> 0 minutes leaves hours unchanged).
  - The cycle after entry issues exactly one increment pulse on the selected enable.
  - The repeat counter (4 bits, cleared on entry) increments on each i_fast_stb and saturates at REPEAT_DELAY.
  - Once saturated, each i_fast_stb issues one increment pulse.
  - An i_fast_stb in the entry cycle counts toward the delay and does not cause a second pulse.
- Only one of o_sec_en, o_min_en and o_hour_en can be high in a set state.
- Reset: state RUN, repeat counter 0, all outputs 0 (o_mode = 0).

## Timing
- All outputs are registered, with one-cycle latency from the qualifying input to the output pulse.
- Cascade example: i_1hz_stb at cycle N -> o_sec_en at N+1. A seconds wrap gives o_min_en at N+2. A minutes wrap gives o_hour_en at N+3.
- Each enable pulse is exactly one sysclk cycle.
- o_mode and o_sec_clr change one cycle after the button level that causes the transition.
- Button release and i_fast_stb in the same cycle: the exit wins and no pulse is issued.
- Reset asserted mid-pulse forces all outputs low immediately, without waiting for a clock edge.

## Configuration
- AUTO_REPEAT_EN defined: auto-repeat behaves as described above.
- AUTO_REPEAT_EN undefined:
  - Only the entry pulse is issued per press; i_fast_stb is ignored.
  - The repeat counter is removed and REPEAT_DELAY is unused.
  - State transitions, o_sec_clr and o_mode are unchanged.

## Structure
- Shared package: state/mode encodings (MODE_RUN = 0, MODE_SET_MIN = 1, MODE_SET_HOUR = 2) and the repeat-counter width constant.
- One sub-module, repeat_timer:
  - Inputs: clear, strobe, REPEAT_DELAY.
  - Output: a fire pulse on the entry cycle and on each post-delay strobe.
  - Compiled out with AUTO_REPEAT_EN undefined; the fire output then reduces to the entry pulse only.
- The FSM and output registers stay in time_set_controller.

## Test plan
- Reset with i_reset_n = 0 mid-run -> all outputs 0 and o_mode = 0 with no clock edge. Release, then i_1hz_stb -> o_sec_en one cycle later.
- RUN, i_1hz_stb at N with i_sec_overflow = 1 at N+1 -> o_sec_en at N+1 and o_min_en at N+2. Add i_min_overflow = 1 at N+2 -> o_hour_en at N+3.
- i_set_minutes held for 10 fast strobes, REPEAT_DELAY = 4 -> o_mode = 1 and o_sec_clr = 1. Expect 1 entry pulse plus 6 repeat pulses on o_min_en, with o_hour_en = 0 and o_sec_en = 0 throughout.
- i_set_minutes and i_set_hours rise together -> o_mode = 2 and a single o_hour_en pulse. Release hours with minutes held -> one RUN cycle, then o_mode = 1 and one o_min_en pulse.
- In SET_HOUR, i_1hz_stb and i_min_overflow pulsed -> no o_sec_en and no o_hour_en beyond the set pulses. Release in the same cycle as i_fast_stb -> no pulse, o_mode = 0 next cycle.
- AUTO_REPEAT_EN undefined, i_set_hours held for 20 fast strobes -> exactly one o_hour_en pulse.
